// File: rtl/blink_meter.sv
// Level-run length meter: measures cycles between edges of d and streams {length, level} on valid/ready.
// Define BLINK_METER_SYNC_EN to pass d through a 2-flop synchronizer first.
module blink_meter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic [WIDTH-1:0] m_data,
    output logic             m_level,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             stalled,
    output logic             dropped
);

    typedef enum logic [1:0] {
        SEEK,
        MEASURE,
        STALL
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_level_q, m_level_d;
    logic             m_valid_q, m_valid_d;
    logic             dropped_q, dropped_d;
    logic             d_prev_q;
    logic             d_s;
    logic             edge_det;
    logic             result;
    logic             load;

`ifdef BLINK_METER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign d_s = sync_q[1];
`else
    assign d_s = d;
`endif

    assign edge_det = (d_s != d_prev_q);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        result    = 1'b0;
        m_data_d  = m_data_q;
        m_level_d = m_level_q;
        m_valid_d = m_valid_q;
        dropped_d = 1'b0;

        // Saturating so an idle input in SEEK/STALL cannot wrap the counter.
        if (edge_det) begin
            count_d = ONE_W;
        end else if (count_q != TIMEOUT_W) begin
            count_d = count_q + ONE_W;
        end

        case (state_q)
            SEEK: begin
                if (edge_det) state_d = MEASURE;
            end
            MEASURE: begin
                if (edge_det) begin
                    result = 1'b1;
                end else if (count_q == TIMEOUT_W) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (edge_det) state_d = MEASURE;
            end
            default: state_d = SEEK;
        endcase

        load = result && (!m_valid_q || m_ready);
        if (load) begin
            m_data_d  = count_q;
            m_level_d = d_prev_q;
            m_valid_d = 1'b1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
        dropped_d = result && m_valid_q && !m_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEEK;
            count_q   <= '0;
            d_prev_q  <= 1'b0;
            m_data_q  <= '0;
            m_level_q <= 1'b0;
            m_valid_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            d_prev_q  <= d_s;
            m_data_q  <= m_data_d;
            m_level_q <= m_level_d;
            m_valid_q <= m_valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_level = m_level_q;
    assign m_valid = m_valid_q;
    assign dropped = dropped_q;
    assign stalled = (state_q == STALL);

endmodule

// File: tb/tb_blink_meter.sv
// Self-checking bench for blink_meter: directed scenarios plus random runs against a time-based model.
module tb_blink_meter;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned TIMEOUT = 8;
`ifdef BLINK_METER_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             d;
    logic [WIDTH-1:0] m_data;
    logic             m_level;
    logic             m_valid;
    logic             m_ready;
    logic             stalled;
    logic             dropped;

    blink_meter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .m_data  (m_data),
        .m_level (m_level),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .stalled (stalled),
        .dropped (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: time-stamped edges rather than a counter/state machine.
    int   cyc       = 0;
    int   last_edge = 0;
    bit   have_ref  = 1'b0;
    logic prev_ds   = 1'b0;
    logic h1        = 1'b0;
    logic h2        = 1'b0;
    logic             e_valid   = 1'b0;
    logic [WIDTH-1:0] e_data    = '0;
    logic             e_level   = 1'b0;
    logic             e_drop    = 1'b0;
    logic             e_stalled = 1'b0;
    logic             lvl       = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic dv, input logic rv, input logic rs);
        logic ds;
        bit   res;
        int   len;
        logic rlev;
        cyc++;
        if (rs) begin
            prev_ds = 1'b0; h1 = 1'b0; h2 = 1'b0;
            have_ref = 1'b0;
            e_valid = 1'b0; e_data = '0; e_level = 1'b0; e_drop = 1'b0; e_stalled = 1'b0;
        end else begin
            ds = SYNC ? h2 : dv;
            h2 = h1;
            h1 = dv;
            res = 1'b0;
            len = 0;
            rlev = prev_ds;
            if (ds != prev_ds) begin
                if (have_ref && (cyc - last_edge) <= int'(TIMEOUT)) begin
                    res = 1'b1;
                    len = cyc - last_edge;
                end
                have_ref  = 1'b1;
                last_edge = cyc;
            end
            prev_ds   = ds;
            e_stalled = have_ref && ((cyc - last_edge) >= int'(TIMEOUT));
            e_drop    = res && e_valid && !rv;
            if (res && (!e_valid || rv)) begin
                e_valid = 1'b1;
                e_data  = WIDTH'(len);
                e_level = rlev;
            end else if (rv) begin
                e_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input logic dv, input logic rv, input logic rs);
        d = dv;
        m_ready = rv;
        rst = rs;
        @(posedge clk);
        model_edge(dv, rv, rs);
        #1;
        check("m_valid", 32'(m_valid), 32'(e_valid));
        check("m_data", 32'(m_data), 32'(e_data));
        check("m_level", 32'(m_level), 32'(e_level));
        check("stalled", 32'(stalled), 32'(e_stalled));
        check("dropped", 32'(dropped), 32'(e_drop));
    endtask

    task automatic hold(input logic lv, input int unsigned n, input int unsigned rdy_pct);
        for (int unsigned i = 0; i < n; i++) begin
            step(lv, ($urandom_range(0, 99) < rdy_pct), 1'b0);
        end
    endtask

    initial begin
        d = 1'b0; m_ready = 1'b0; rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        hold(1'b0, 4, 100);

        // Square wave, toggle every 3
        for (int i = 0; i < 10; i++) begin lvl = ~lvl; hold(lvl, 3, 100); end
        // Asymmetric high 5 / low 2
        for (int i = 0; i < 5; i++) begin hold(1'b1, 5, 100); hold(1'b0, 2, 100); end
        lvl = 1'b0;
        hold(lvl, 6, 100);

        // Back-pressure: toggle every 4, ready low for 12 cycles
        for (int i = 0; i < 28; i++) begin
            if (i % 4 == 0) lvl = ~lvl;
            step(lvl, (i >= 12), 1'b0);
        end

        // Stall then recovery
        lvl = ~lvl; hold(lvl, 14, 100);
        lvl = ~lvl; hold(lvl, 3, 100);
        lvl = ~lvl; hold(lvl, 3, 100);
        // Edge exactly at TIMEOUT
        for (int i = 0; i < 4; i++) begin lvl = ~lvl; hold(lvl, TIMEOUT, 100); end
        lvl = ~lvl; hold(lvl, TIMEOUT + 1, 100);
        lvl = ~lvl; hold(lvl, TIMEOUT - 1, 100);

        // Reset mid-run while a result is pending
        for (int i = 0; i < 3; i++) begin lvl = ~lvl; hold(lvl, 4, 0); end
        step(lvl, 1'b0, 1'b1);
        hold(lvl, 5, 100);
        for (int i = 0; i < 4; i++) begin lvl = ~lvl; hold(lvl, 3 + i, 100); end

        // Random runs with random back-pressure
        for (int i = 0; i < 250; i++) begin
            int unsigned len;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                              : $urandom_range(1, 10);
            lvl = ~lvl;
            hold(lvl, len, 70);
            if ($urandom_range(0, 99) == 0) step(lvl, 1'b0, 1'b1);
        end
        hold(lvl, 4, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
